// File: rtl/mem_io_ctrl.sv
// Memory/MMIO glue: store byte lanes, load extension, UART TX/RX handshake and perf counters.
// Build option: define MEM_IO_CTRL_COUNTERS_EN to implement the cycle/instruction counters.

module mem_io_ctrl #(
    parameter int DMEM_AWIDTH = 14,
    parameter int IMEM_AWIDTH = 14,
    parameter int BIOS_AWIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic                   req_we,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    input  logic [2:0]             req_funct3,
    input  logic                   exec_from_bios,
    input  logic                   inst_retire,
    output logic [DMEM_AWIDTH-1:0] dmem_addr,
    output logic [31:0]            dmem_din,
    output logic [3:0]             dmem_wbe,
    output logic [IMEM_AWIDTH-1:0] imem_addr,
    output logic [31:0]            imem_din,
    output logic [3:0]             imem_wbe,
    output logic [BIOS_AWIDTH-1:0] bios_addr,
    input  logic [31:0]            dmem_dout,
    input  logic [31:0]            bios_dout,
    input  logic [7:0]             uart_rx_data,
    input  logic                   uart_rx_valid,
    output logic                   uart_rx_ready,
    output logic [7:0]             uart_tx_data,
    output logic                   uart_tx_valid,
    input  logic                   uart_tx_ready,
    output logic [31:0]            load_data
);

    typedef enum logic [1:0] {
        RGN_NONE,
        RGN_DMEM,
        RGN_BIOS,
        RGN_MMIO
    } region_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RX     = 8'h04;
    localparam logic [7:0] OFF_TX     = 8'h08;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_INST   = 8'h14;
    localparam logic [7:0] OFF_CLEAR  = 8'h18;

    logic [3:0]  region_nib;
    logic        hit_dmem;
    logic        hit_imem;
    logic        hit_bios;
    logic        hit_mmio;
    logic [7:0]  mmio_off;
    logic        req_store;
    logic        req_load;
    region_t     req_region;

    logic [3:0]  store_mask;
    logic [31:0] store_data;

    logic        wr_tx;
    logic        rd_rx;
    logic [31:0] cycle_val;
    logic [31:0] inst_val;
    logic [31:0] mmio_rdata;

    region_t     ld_region;
    logic [1:0]  ld_off;
    logic [2:0]  ld_funct3;
    logic [31:0] ld_mmio;
    logic [31:0] ld_src;
    logic [31:0] ld_shift;

    logic        unused_inputs;

    assign region_nib = req_addr[31:28];
    assign hit_dmem   = (region_nib[3:2] == 2'b00) && region_nib[0];
    assign hit_imem   = (region_nib[3:1] == 3'b001);
    assign hit_bios   = (region_nib == 4'b0100);
    assign hit_mmio   = (region_nib == 4'b1000);
    assign mmio_off   = req_addr[7:0];

    // rst masks every side effect of the request in the same cycle
    assign req_store  = req_valid && req_we && !rst;
    assign req_load   = req_valid && !req_we && !rst;

    always_comb begin
        if (hit_dmem) begin
            req_region = RGN_DMEM;
        end else if (hit_bios) begin
            req_region = RGN_BIOS;
        end else if (hit_mmio) begin
            req_region = RGN_MMIO;
        end else begin
            req_region = RGN_NONE;
        end
    end

    assign dmem_addr = req_addr[DMEM_AWIDTH+1:2];
    assign imem_addr = req_addr[IMEM_AWIDTH+1:2];
    assign bios_addr = req_addr[BIOS_AWIDTH+1:2];

    always_comb begin
        store_mask = 4'b0000;
        store_data = req_wdata;
        case (req_funct3)
            F3_B: begin
                store_mask = 4'b0001 << req_addr[1:0];
                store_data = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                store_mask = req_addr[0] ? 4'b0000 : (4'b0011 << {req_addr[1], 1'b0});
                store_data = {2{req_wdata[15:0]}};
            end
            F3_W: begin
                store_mask = (req_addr[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
            end
            default: store_mask = 4'b0000;
        endcase
    end

    // region 0011 hits both memories so code can be copied while running from BIOS
    assign dmem_wbe = (req_store && hit_dmem) ? store_mask : 4'b0000;
    assign imem_wbe = (req_store && hit_imem && exec_from_bios) ? store_mask : 4'b0000;
    assign dmem_din = store_data;
    assign imem_din = store_data;

    assign wr_tx         = req_store && hit_mmio && (mmio_off == OFF_TX);
    assign rd_rx         = req_load && hit_mmio && (mmio_off == OFF_RX);
    assign uart_rx_ready = rd_rx;

    always_ff @(posedge clk) begin
        if (rst) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= 8'h00;
        end else if (uart_tx_valid) begin
            if (uart_tx_ready) begin
                uart_tx_valid <= 1'b0;
            end
        end else if (wr_tx) begin
            uart_tx_valid <= 1'b1;
            uart_tx_data  <= req_wdata[7:0];
        end
    end

`ifdef MEM_IO_CTRL_COUNTERS_EN
    logic        wr_clear;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;

    assign wr_clear = req_store && hit_mmio && (mmio_off == OFF_CLEAR);

    always_ff @(posedge clk) begin
        if (rst || wr_clear) begin
            cycle_cnt <= 32'h0;
            inst_cnt  <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'h1;
            inst_cnt  <= inst_cnt + {31'h0, inst_retire};
        end
    end

    assign cycle_val = cycle_cnt;
    assign inst_val  = inst_cnt;
`else
    assign cycle_val = 32'h0;
    assign inst_val  = 32'h0;
`endif

    assign unused_inputs = ^{req_addr, inst_retire};

    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_off)
            OFF_STATUS: mmio_rdata = {30'h0, uart_rx_valid, ~uart_tx_valid};
            OFF_RX:     mmio_rdata = {24'h0, uart_rx_data};
            OFF_CYCLE:  mmio_rdata = cycle_val;
            OFF_INST:   mmio_rdata = inst_val;
            default:    mmio_rdata = 32'h0;
        endcase
    end

    // region falls back to NONE between loads so load_data reads 0 when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_region <= RGN_NONE;
            ld_off    <= 2'b00;
            ld_funct3 <= 3'b000;
            ld_mmio   <= 32'h0;
        end else if (req_load) begin
            ld_region <= req_region;
            ld_off    <= req_addr[1:0];
            ld_funct3 <= req_funct3;
            ld_mmio   <= mmio_rdata;
        end else begin
            ld_region <= RGN_NONE;
        end
    end

    always_comb begin
        case (ld_region)
            RGN_DMEM: ld_src = dmem_dout;
            RGN_BIOS: ld_src = bios_dout;
            RGN_MMIO: ld_src = ld_mmio;
            default:  ld_src = 32'h0;
        endcase
        ld_shift = ld_src >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_B:    load_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            F3_H:    load_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            F3_W:    load_data = ld_shift;
            F3_BU:   load_data = {24'h0, ld_shift[7:0]};
            F3_HU:   load_data = {16'h0, ld_shift[15:0]};
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Self-checking bench for mem_io_ctrl: vector tables, directed UART/counter/reset sequences,
// and a randomized run against a behavioural model.

module tb_mem_io_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        exec_from_bios, inst_retire;
    logic [13:0] dmem_addr, imem_addr;
    logic [11:0] bios_addr;
    logic [31:0] dmem_din, imem_din, dmem_dout, bios_dout, load_data;
    logic [3:0]  dmem_wbe, imem_wbe;
    logic [7:0]  uart_rx_data, uart_tx_data;
    logic        uart_rx_valid, uart_rx_ready, uart_tx_valid, uart_tx_ready;

    int errors = 0;
    int checks = 0;

    mem_io_ctrl #(.DMEM_AWIDTH(14), .IMEM_AWIDTH(14), .BIOS_AWIDTH(12)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3),
        .exec_from_bios(exec_from_bios), .inst_retire(inst_retire),
        .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_wbe(dmem_wbe),
        .imem_addr(imem_addr), .imem_din(imem_din), .imem_wbe(imem_wbe),
        .bios_addr(bios_addr), .dmem_dout(dmem_dout), .bios_dout(bios_dout),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
        .load_data(load_data)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3);
        req_valid  = v;
        req_we     = we;
        req_addr   = a;
        req_wdata  = wd;
        req_funct3 = f3;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_cyc, m_ins;
    logic        m_txv;
    logic [7:0]  m_txd;
    int          p_rg;
    logic [1:0]  p_off;
    logic [2:0]  p_f3;
    logic [31:0] p_mv;

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] b;
        b = 4'h0;
        case (f3)
            3'd0: b[off] = 1'b1;
            3'd1: b = (off == 2'd0) ? 4'h3 : ((off == 2'd2) ? 4'hC : 4'h0);
            3'd2: b = (off == 2'd0) ? 4'hF : 4'h0;
            default: b = 4'h0;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] w);
        if (f3 == 3'd0) return {w[7:0], w[7:0], w[7:0], w[7:0]};
        if (f3 == 3'd1) return {w[15:0], w[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] ext_load(input int rg, input logic [1:0] off,
                                             input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] s;
        if (rg == 0) return 32'h0;
        s = w >> (8 * int'(off));
        case (f3)
            3'd0: return 32'($signed(s[7:0]));
            3'd1: return 32'($signed(s[15:0]));
            3'd2: return s;
            3'd4: return {24'h0, s[7:0]};
            3'd5: return {16'h0, s[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int region_of(input logic [3:0] nib);
        if (nib == 4'h1 || nib == 4'h3) return 1;
        if (nib == 4'h4) return 2;
        if (nib == 4'h8) return 3;
        return 0;
    endfunction

    function automatic logic [31:0] mmio_val(input logic [7:0] off);
        case (off)
            8'h00: return {30'h0, uart_rx_valid, ~m_txv};
            8'h04: return {24'h0, uart_rx_data};
`ifdef MEM_IO_CTRL_COUNTERS_EN
            8'h10: return m_cyc;
            8'h14: return m_ins;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- vector tables ----------------
    typedef struct {
        logic        valid, we, efb;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        logic [3:0]  dwbe, iwbe;
        logic [31:0] din;
    } st_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] dout, bdout, exp;
    } ld_vec_t;

    st_vec_t st_tab[14];
    ld_vec_t ld_tab[10];

    logic [3:0]  nibs[8];
    logic [7:0]  offs[8];
    logic [2:0]  ldf3[5];
    logic [3:0]  r_nib;
    logic [7:0]  r_off;
    logic [31:0] cyc_exp, ins_exp;
    logic [31:0] e_ld;
    logic [3:0]  e_mask;
    logic        clr;

    initial begin
        st_tab[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 32'h1000_0006, 32'h0000_00AB, 4'b0100, 4'b0000, 32'hABAB_ABAB};
        st_tab[1]  = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h2000_0010, 32'h1122_3344, 4'b0000, 4'b0000, 32'h1122_3344};
        st_tab[2]  = '{1'b1, 1'b1, 1'b1, 3'd2, 32'h2000_0010, 32'h1122_3344, 4'b0000, 4'b1111, 32'h1122_3344};
        st_tab[3]  = '{1'b1, 1'b1, 1'b0, 3'd1, 32'h1000_0002, 32'h1234_CDEF, 4'b1100, 4'b0000, 32'hCDEF_CDEF};
        st_tab[4]  = '{1'b1, 1'b1, 1'b0, 3'd1, 32'h1000_0001, 32'h1234_CDEF, 4'b0000, 4'b0000, 32'hCDEF_CDEF};
        st_tab[5]  = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h1000_0002, 32'hDEAD_BEEF, 4'b0000, 4'b0000, 32'hDEAD_BEEF};
        st_tab[6]  = '{1'b1, 1'b1, 1'b1, 3'd2, 32'h3000_0004, 32'hDEAD_BEEF, 4'b1111, 4'b1111, 32'hDEAD_BEEF};
        st_tab[7]  = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h3000_0004, 32'hDEAD_BEEF, 4'b1111, 4'b0000, 32'hDEAD_BEEF};
        st_tab[8]  = '{1'b0, 1'b1, 1'b1, 3'd2, 32'h1000_0000, 32'hCAFE_F00D, 4'b0000, 4'b0000, 32'hCAFE_F00D};
        st_tab[9]  = '{1'b1, 1'b0, 1'b1, 3'd2, 32'h1000_0000, 32'hCAFE_F00D, 4'b0000, 4'b0000, 32'hCAFE_F00D};
        st_tab[10] = '{1'b1, 1'b1, 1'b1, 3'd2, 32'h4000_0000, 32'h0102_0304, 4'b0000, 4'b0000, 32'h0102_0304};
        st_tab[11] = '{1'b1, 1'b1, 1'b1, 3'd0, 32'h3000_000B, 32'h0000_005A, 4'b1000, 4'b1000, 32'h5A5A_5A5A};
        st_tab[12] = '{1'b1, 1'b1, 1'b1, 3'd1, 32'h2000_000E, 32'h0000_BEEF, 4'b0000, 4'b1100, 32'hBEEF_BEEF};
        st_tab[13] = '{1'b1, 1'b1, 1'b1, 3'd0, 32'h9000_0000, 32'h0000_0077, 4'b0000, 4'b0000, 32'h7777_7777};

        ld_tab[0] = '{32'h1000_0003, 3'd0, 32'h80FF_FF7F, 32'h0, 32'hFFFF_FF80};
        ld_tab[1] = '{32'h1000_0003, 3'd4, 32'h80FF_FF7F, 32'h0, 32'h0000_0080};
        ld_tab[2] = '{32'h1000_0002, 3'd1, 32'h80FF_FF7F, 32'h0, 32'hFFFF_80FF};
        ld_tab[3] = '{32'h1000_0000, 3'd5, 32'h80FF_FF7F, 32'h0, 32'h0000_FF7F};
        ld_tab[4] = '{32'h1000_0000, 3'd2, 32'h80FF_FF7F, 32'h0, 32'h80FF_FF7F};
        ld_tab[5] = '{32'h4000_0001, 3'd0, 32'hFFFF_FFFF, 32'h0000_7F00, 32'h0000_007F};
        ld_tab[6] = '{32'h2000_0000, 3'd2, 32'h1234_5678, 32'h1234_5678, 32'h0};
        ld_tab[7] = '{32'h5000_0000, 3'd2, 32'h1234_5678, 32'h1234_5678, 32'h0};
        ld_tab[8] = '{32'h3000_0002, 3'd5, 32'hCAFE_1234, 32'h0, 32'h0000_CAFE};
        ld_tab[9] = '{32'h1000_0001, 3'd0, 32'h0000_AB00, 32'h0, 32'hFFFF_FFAB};

        nibs = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hF};
        offs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h1C};
        ldf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

`ifdef MEM_IO_CTRL_COUNTERS_EN
        cyc_exp = 32'd10;
        ins_exp = 32'd3;
`else
        cyc_exp = 32'd0;
        ins_exp = 32'd0;
`endif

        // ---------- reset ----------
        idle();
        rst = 1'b1;
        exec_from_bios = 1'b0; inst_retire = 1'b0;
        dmem_dout = 32'h0; bios_dout = 32'h0;
        uart_rx_data = 8'h00; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
        tick();
        tick();
        drive(1'b1, 1'b1, 32'h1000_0000, 32'h1234_5678, 3'd2);
        @(negedge clk);
        chk("rst_dmem_wbe", 32'(dmem_wbe), 32'h0);
        chk("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_rx_ready", 32'(uart_rx_ready), 32'h0);
        tick();

        // ---------- store table ----------
        for (int i = 0; i < 14; i++) begin
            exec_from_bios = st_tab[i].efb;
            drive(st_tab[i].valid, st_tab[i].we, st_tab[i].addr, st_tab[i].wdata, st_tab[i].f3);
            @(negedge clk);
            chk($sformatf("st%0d_dmem_wbe", i), 32'(dmem_wbe), 32'(st_tab[i].dwbe));
            chk($sformatf("st%0d_imem_wbe", i), 32'(imem_wbe), 32'(st_tab[i].iwbe));
            chk($sformatf("st%0d_dmem_din", i), dmem_din, st_tab[i].din);
            chk($sformatf("st%0d_imem_din", i), imem_din, st_tab[i].din);
            chk($sformatf("st%0d_dmem_addr", i), 32'(dmem_addr), 32'(st_tab[i].addr[15:2]));
            chk($sformatf("st%0d_imem_addr", i), 32'(imem_addr), 32'(st_tab[i].addr[15:2]));
            chk($sformatf("st%0d_bios_addr", i), 32'(bios_addr), 32'(st_tab[i].addr[13:2]));
            tick();
        end
        idle();
        exec_from_bios = 1'b0;

        // ---------- load table ----------
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, ld_tab[i].addr, 32'h0, ld_tab[i].f3);
            dmem_dout = ~ld_tab[i].dout;
            bios_dout = ~ld_tab[i].bdout;
            tick();
            idle();
            dmem_dout = ld_tab[i].dout;
            bios_dout = ld_tab[i].bdout;
            @(negedge clk);
            chk($sformatf("ld%0d_load_data", i), load_data, ld_tab[i].exp);
            tick();
        end

        // ---------- UART TX hold, drop, handshake ----------
        drive(1'b1, 1'b1, 32'h8000_0008, 32'h0000_0041, 3'd2);
        tick();
        for (int i = 0; i < 5; i++) begin
            idle();
            uart_rx_valid = 1'b0;
            if (i == 2) drive(1'b1, 1'b1, 32'h8000_0008, 32'h0000_0042, 3'd2);
            if (i == 3) begin
                drive(1'b1, 1'b0, 32'h8000_0000, 32'h0, 3'd2);
                uart_rx_valid = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("tx_hold%0d_valid", i), 32'(uart_tx_valid), 32'h1);
            chk($sformatf("tx_hold%0d_data", i), 32'(uart_tx_data), 32'h41);
            if (i == 4) chk("status_busy", load_data, 32'h2);
            tick();
        end
        idle();
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b1;
        @(negedge clk);
        chk("tx_hs_valid", 32'(uart_tx_valid), 32'h1);
        tick();
        uart_tx_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h8000_0000, 32'h0, 3'd2);
        @(negedge clk);
        chk("tx_done_valid", 32'(uart_tx_valid), 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("status_idle", load_data, 32'h1);
        tick();

        // ---------- UART RX pop ----------
        uart_rx_data = 8'h5C;
        drive(1'b1, 1'b0, 32'h8000_0004, 32'h0, 3'd2);
        @(negedge clk);
        chk("rx_pulse", 32'(uart_rx_ready), 32'h1);
        tick();
        idle();
        uart_rx_data = 8'h99;
        @(negedge clk);
        chk("rx_pulse_end", 32'(uart_rx_ready), 32'h0);
        chk("rx_data", load_data, 32'h5C);
        drive(1'b1, 1'b1, 32'h8000_0004, 32'h0, 3'd2);
        #1;
        chk("rx_store_nopop", 32'(uart_rx_ready), 32'h0);
        tick();
        idle();

        // ---------- counters ----------
        drive(1'b1, 1'b1, 32'h8000_0018, 32'h0, 3'd2);
        inst_retire = 1'b1;
        tick();
        inst_retire = 1'b0;
        drive(1'b1, 1'b0, 32'h8000_0014, 32'h0, 3'd2);
        tick();
        idle();
        @(negedge clk);
        chk("clr_priority", load_data, 32'h0);
        drive(1'b1, 1'b1, 32'h8000_0018, 32'hFFFF_FFFF, 3'd2);
        tick();
        idle();
        for (int i = 0; i < 10; i++) begin
            inst_retire = (i == 2 || i == 5 || i == 9);
            tick();
        end
        inst_retire = 1'b0;
        drive(1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'd2);
        tick();
        drive(1'b1, 1'b0, 32'h8000_0014, 32'h0, 3'd2);
        @(negedge clk);
        chk("cycle_count", load_data, cyc_exp);
        tick();
        idle();
        @(negedge clk);
        chk("inst_count", load_data, ins_exp);
        tick();

        // ---------- reset during TX ----------
        drive(1'b1, 1'b1, 32'h8000_0008, 32'h0000_0077, 3'd2);
        tick();
        idle();
        @(negedge clk);
        chk("rtx_pending", 32'(uart_tx_valid), 32'h1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h1000_0000, 32'h5555_5555, 3'd2);
        @(negedge clk);
        chk("rtx_wbe_masked", 32'(dmem_wbe), 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h8000_0004, 32'h0, 3'd2);
        @(negedge clk);
        chk("rtx_valid_cleared", 32'(uart_tx_valid), 32'h0);
        chk("rtx_nopop", 32'(uart_rx_ready), 32'h0);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'd2);
        @(negedge clk);
        chk("rtx_load_cleared", load_data, 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("rtx_cycle_zero", load_data, 32'h0);
        tick();

        // ---------- randomized run against the model ----------
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        m_cyc = 32'h0; m_ins = 32'h0; m_txv = 1'b0; m_txd = 8'h0;
        p_rg = 0; p_off = 2'b00; p_f3 = 3'd0; p_mv = 32'h0;
        for (int n = 0; n < 400; n++) begin
            r_nib = nibs[$urandom_range(0, 7)];
            r_off = (r_nib == 4'h8) ? offs[$urandom_range(0, 7)] : 8'($urandom);
            req_valid  = ($urandom_range(0, 3) != 0);
            req_we     = 1'($urandom);
            req_addr   = {r_nib, 20'($urandom), r_off};
            req_wdata  = $urandom;
            req_funct3 = req_we ? 3'($urandom_range(0, 2)) : ldf3[$urandom_range(0, 4)];
            exec_from_bios = 1'($urandom);
            inst_retire    = 1'($urandom);
            dmem_dout      = $urandom;
            bios_dout      = $urandom;
            uart_rx_data   = 8'($urandom);
            uart_rx_valid  = 1'($urandom);
            uart_tx_ready  = ($urandom_range(0, 2) == 0);

            @(negedge clk);
            e_mask = lane_mask(req_funct3, req_addr[1:0]);
            chk("rnd_dmem_wbe", 32'(dmem_wbe),
                32'((req_valid && req_we && (r_nib == 4'h1 || r_nib == 4'h3)) ? e_mask : 4'h0));
            chk("rnd_imem_wbe", 32'(imem_wbe),
                32'((req_valid && req_we && exec_from_bios && (r_nib == 4'h2 || r_nib == 4'h3)) ? e_mask : 4'h0));
            if (req_we) chk("rnd_din", dmem_din, lane_data(req_funct3, req_wdata));
            chk("rnd_dmem_addr", 32'(dmem_addr), (req_addr % 32'h1_0000) / 4);
            chk("rnd_bios_addr", 32'(bios_addr), (req_addr % 32'h4000) / 4);
            chk("rnd_rx_ready", 32'(uart_rx_ready),
                32'(req_valid && !req_we && r_nib == 4'h8 && r_off == 8'h04));
            chk("rnd_tx_valid", 32'(uart_tx_valid), 32'(m_txv));
            if (m_txv) chk("rnd_tx_data", 32'(uart_tx_data), 32'(m_txd));
            e_ld = ext_load(p_rg, p_off, p_f3,
                            (p_rg == 1) ? dmem_dout : ((p_rg == 2) ? bios_dout : p_mv));
            chk("rnd_load_data", load_data, e_ld);

            @(posedge clk);
            if (req_valid && !req_we) begin
                p_rg  = region_of(r_nib);
                p_off = req_addr[1:0];
                p_f3  = req_funct3;
                p_mv  = mmio_val(r_off);
            end else begin
                p_rg = 0;
            end
            if (m_txv) begin
                if (uart_tx_ready) m_txv = 1'b0;
            end else if (req_valid && req_we && r_nib == 4'h8 && r_off == 8'h08) begin
                m_txv = 1'b1;
                m_txd = req_wdata[7:0];
            end
            clr   = req_valid && req_we && r_nib == 4'h8 && r_off == 8'h18;
            m_cyc = clr ? 32'h0 : m_cyc + 32'h1;
            m_ins = clr ? 32'h0 : m_ins + 32'(inst_retire);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 SHALL have parameter DMEM_AWIDTH, default 14: DMEM word-address width.
REQ-002 SHALL have parameter IMEM_AWIDTH, default 14: IMEM word-address width.
REQ-003 SHALL have parameter BIOS_AWIDTH, default 12: BIOS word-address width.
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports clk (input, 1) and rst (input, 1) come first.
REQ-005 SHALL have these request inputs:
- req_valid (1): memory op in EX.
- req_we (1): store.
- req_addr (32): byte address.
- req_wdata (32): store data.
- req_funct3 (3): access size and sign.
REQ-006 SHALL have these status inputs:
- exec_from_bios (1): fetch PC is in BIOS.
- inst_retire (1): one instruction retired this cycle.
REQ-007 SHALL have these memory outputs:
- dmem_addr (DMEM_AWIDTH), dmem_din (32), dmem_wbe (4).
- imem_addr (IMEM_AWIDTH), imem_din (32), imem_wbe (4).
- bios_addr (BIOS_AWIDTH).
REQ-008 SHALL have memory read-data inputs dmem_dout (32) and bios_dout (32).
REQ-009 SHALL have UART ports:
- uart_rx_data (in, 8), uart_rx_valid (in, 1), uart_rx_ready (out, 1).
- uart_tx_data (out, 8), uart_tx_valid (out, 1), uart_tx_ready (in, 1).
REQ-010 SHALL have output load_data (32): extended load result, valid in the cycle after the request.

Function
REQ-011 SHALL decode the region from req_addr[31:28]:
- 00x1: DMEM read/write.
- 001x: IMEM write.
- 0100: BIOS read.
- 1000: MMIO.
- Any other value: no write, and a load returns 0.
REQ-012 SHALL drive all three memory address outputs from req_addr[N+1:2] every cycle, regardless of req_valid.
REQ-013 SHALL generate store byte enables:
- sb: 0001<<addr[1:0], data byte replicated to all four lanes.
- sh: 0011<<{addr[1],0}, data halfword replicated to both halves.
- sw: 1111.
REQ-014 SHALL suppress the write (wbe=0000) for a misaligned sh (addr[0]=1) or sw (addr[1:0]≠0), and whenever req_valid=0 or req_we=0.
REQ-015 SHALL gate IMEM writes with exec_from_bios; with exec_from_bios=0, imem_wbe=0000.
REQ-016 SHALL apply addr 0011 stores to both DMEM and IMEM in the same cycle.
REQ-017 SHALL register region, addr[1:0], funct3 and MMIO read value on a valid load; in the next cycle it selects the source, shifts by the byte offset, and sign- or zero-extends (lb/lh/lw/lbu/lhu) into load_data.
REQ-018 SHALL implement these MMIO offsets (low byte of the address):
- 0x00 read: {30'b0, uart_rx_valid, ~uart_tx_valid}.
- 0x04 read: {24'b0, uart_rx_data}, plus a one-cycle uart_rx_ready pulse in the request cycle.
- 0x08 write: latch req_wdata[7:0] into uart_tx_data and set uart_tx_valid.
- 0x10 read: cycle counter.
- 0x14 read: instruction counter.
- 0x18 write (any data): clear both counters.
- Other MMIO offsets: read 0, write ignored.
REQ-019 SHALL hold uart_tx_valid=1 and uart_tx_data stable until a cycle with uart_tx_ready=1 (handshake), then clear uart_tx_valid in the following cycle.
REQ-020 SHALL drop a 0x08 write that arrives while uart_tx_valid=1; the pending byte is kept.
REQ-021 SHALL still pulse uart_rx_ready on a 0x04 read when uart_rx_valid=0; the load returns the current uart_rx_data.
REQ-022 SHALL increment the cycle counter every cycle and the instruction counter on inst_retire; both wrap 0xFFFFFFFF→0.
REQ-023 SHALL let a counter-clear write take priority over a simultaneous increment, giving 0 next cycle.
REQ-024 SHALL return the pre-update counter value on a counter read.

Reset
REQ-025 SHALL, on rst, clear the counters, uart_tx_valid, uart_rx_ready, load_data and the registered load state to 0 in the next cycle.
REQ-026 SHALL abort a pending TX on rst, with no handshake.
REQ-027 SHALL suppress all writes and pops during any cycle with rst=1.

Configuration
REQ-028 SHALL have the macro MEM_IO_CTRL_COUNTERS_EN.
- Defined: both counters and offsets 0x10/0x14/0x18 are implemented.
- Undefined: no counter flops; reads of 0x10/0x14 return 0; writes to 0x18 are ignored.

Verification
REQ-029 SHALL show sb of 0x000000AB to 0x10000006 → dmem_wbe=0100 and dmem_din=0xABABABAB.
REQ-030 SHALL show sw to 0x20000010 with exec_from_bios=0 → imem_wbe=0000; with exec_from_bios=1 → imem_wbe=1111.
REQ-031 SHALL show lb at 0x10000003, with dmem_dout=0x80FF_FF7F the cycle after → load_data=0xFFFFFF80; lbu → 0x00000080.
REQ-032 SHALL show a write of 0x41 to 0x80000008 with uart_tx_ready held 0 for 5 cycles → valid held and data 0x41; a second write of 0x42 is dropped; ready=1 → valid clears next cycle.
REQ-033 SHALL show a write to 0x80000018 followed by 10 cycles with inst_retire high in 3 of them → 0x80000010 reads 10 and 0x80000014 reads 3 (both 0 with the macro undefined).
REQ-034 SHALL show rst asserted mid-TX → uart_tx_valid=0 and counters=0 next cycle.
